fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Downstream drain stage for the 4-bit synchronous FIFO. Pops one word at a time through the FIFO's `read`/`empthy`/`data_out` interface and shifts it out on a single-wire asynchronous serial line: start bit, data LSB first, optional parity, stop bit. Bit timing is a fixed number of `clk` cycles. It is the FIFO's only reader, so it fully owns the FIFO's read side.

## Interface
- `WIDTH`, 4: data word width; must match the FIFO's width.
- `CLKS_PER_BIT`, 4: `clk` cycles per serial bit, legal range ≥2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `enable`  input  1  permits starting a new frame.
- `empty`  input  1  FIFO `empthy` flag.
- `fifo_data`  input  WIDTH  FIFO `data_out`, registered; valid the cycle after the FIFO samples `read`.
- `read`  output  1  registered pop strobe to the FIFO; high for exactly one cycle per frame.
- `tx`  output  1  registered serial line; idles high.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  registered one-cycle pulse on the last cycle of the stop bit.

## Operation
- State sequence: IDLE → POP → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE**
  - `tx`=1.
  - If `enable`=1 and `empty`=0, the next state is POP and `read`<=1.
  - Otherwise the block stays in IDLE.
  - `empty` and `enable` are sampled only in IDLE.
- **POP**
  - `read`=1 for this one cycle; the FIFO samples it at the closing edge.
  - Next state is LOAD, and `read`<=0.
- **LOAD**
  - `fifo_data` is valid in this cycle.
  - At the closing edge: the shift register <= `fifo_data`, the parity accumulator <= XOR of `fifo_data`, and `tx`<=0.
  - Next state is START.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles.
- **DATA**
  - Shifts out `WIDTH` bits, LSB first.
  - Each bit is held for `CLKS_PER_BIT` cycles.
  - Bit counter width is clog2(WIDTH).
- **PARITY** (only when `PARITY_EN`=1)
  - `tx` = XOR(data) XOR `PARITY_ODD` for `CLKS_PER_BIT` cycles.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - `done`=1 on the final cycle; next state is IDLE.
- Bit counter: the baud counter runs 0..`CLKS_PER_BIT`-1 and wraps to 0 on every bit boundary.
- `enable` deasserted mid-frame: the current frame completes normally; no further pop occurs.
- `empty` rising after the pop: no effect on the current frame.
- The block never asserts `read` while `empty`=1 was observed in IDLE, so underflow is impossible.
- Reset (`rst`=0, any time, asynchronous):
  - State goes to IDLE.
  - `tx`=1, `read`=0, `busy`=0, `done`=0.
  - Shift register and counters are cleared.
  - A partially sent word is lost; the FIFO has already popped it.

## Timing
- Cycle n: IDLE with `enable`=1 and `empty`=0.
- Cycle n+1: `read`=1.
- Cycle n+2: LOAD.
- Cycle n+3: first cycle of `tx`=0.
- Frame length from the `tx` falling edge: F = (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT cycles.
- Back-to-back streaming:
  - After `done`, there are 3 extra `tx`=1 cycles (IDLE, POP, LOAD) before the next start bit.
  - Start-bit period is F + 3 cycles.
- `busy` rises in cycle n+1 and falls in the cycle after `done`.

## Test plan
- Reset: hold `rst`=0, then release with `empty`=1 → `tx`=1, `read`=0, `busy`=0, `done`=0. No `read` occurs for 50 cycles.
- Single word, defaults, FIFO holding 4'hA:
  - `read` is high exactly one cycle.
  - From the `tx` fall, `tx` = 0,0,1,0,1,1, each level held 4 cycles (24 total).
  - `done` pulses on cycle 24.
  - FIFO ends empty.
- Stream of 4'h3, 4'hC, 4'hF:
  - Three frames, LSB-first contents correct.
  - Start-bit spacing is 27 cycles.
  - Exactly three `read` pulses.
  - Afterwards the block returns to IDLE with `tx`=1.
- Parity, `PARITY_EN`=1:
  - Word 4'h7 with `PARITY_ODD`=0 → parity bit 1.
  - Word 4'h7 with `PARITY_ODD`=1 → parity bit 0.
  - Frame is 28 cycles.
- `enable` gating:
  - `enable`=0 with a non-empty FIFO → no `read`.
  - Drop `enable` during a DATA bit → that frame completes and `done` pulses; no second `read`.
- Reset mid-frame:
  - Assert `rst` during DATA bit 2 → `tx`=1 and `busy`=0 immediately, without waiting for a clock edge.
  - After release, the next FIFO word is sent as a complete frame.

Source files
------------

// File: rtl/fifo_serial_tx_if.sv
// Read-side handshake between the synchronous FIFO and its serial drain stage.
interface fifo_serial_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             read;
    logic             empty;
    logic [WIDTH-1:0] fifo_data;

    modport master (output read, input empty, input fifo_data);
    modport slave  (input read, output empty, output fifo_data);
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops words from the FIFO and shifts each out as a serial frame:
// start bit, data LSB first, optional parity, stop bit.
module fifo_serial_tx #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    fifo_serial_tx_if.master        fifo,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_DONE = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic              ODD_BIT   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shreg_shift;
    logic              par;
    logic [BAUD_W-1:0] baud;
    logic [BIT_W-1:0]  bit_cnt;
    logic              baud_last;

    assign shreg_shift = shreg >> 1;
    assign baud_last   = (baud == BAUD_LAST);

    // Frame sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            fifo.read <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shreg     <= '0;
            par       <= 1'b0;
            baud      <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    baud    <= '0;
                    bit_cnt <= '0;
                    if (enable && !fifo.empty) begin
                        state     <= POP;
                        fifo.read <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                POP: begin
                    fifo.read <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: begin
                    shreg <= fifo.fifo_data;
                    par   <= ^fifo.fifo_data;
                    tx    <= 1'b0;
                    baud  <= '0;
                    state <= START;
                end
                START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par ^ ODD_BIT;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            shreg   <= shreg_shift;
                            tx      <= shreg_shift[0];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    // Registered one cycle early so the pulse lands on the final stop cycle.
                    done <= (baud == BAUD_DONE);
                    if (baud_last) begin
                        baud  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    tx        <= 1'b1;
                    fifo.read <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: three instances (no parity, even, odd) each drained from a small FIFO model.
module tb_fifo_serial_tx;
    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en [3];

    logic tx_w    [3];
    logic busy_w  [3];
    logic done_w  [3];
    logic read_w  [3];
    logic empty_w [3];
    int   rc_w    [3];

    logic [3:0] mem [3][16];
    int         wr_ptr [3];

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g
        fifo_serial_tx_if #(.WIDTH(4)) bus ();
        int         rd_ptr   = 0;
        int         read_cnt = 0;
        logic [3:0] dout     = 4'h0;

        assign bus.empty     = (wr_ptr[gi] == rd_ptr);
        assign bus.fifo_data = dout;

        always @(posedge clk) begin
            if (bus.read) read_cnt <= read_cnt + 1;
            if (bus.read && !bus.empty) begin
                dout   <= mem[gi][4'(rd_ptr)];
                rd_ptr <= rd_ptr + 1;
            end
        end

        fifo_serial_tx #(
            .WIDTH(4), .CLKS_PER_BIT(CPB),
            .PARITY_EN((gi > 0) ? 1 : 0), .PARITY_ODD((gi == 2) ? 1 : 0)
        ) dut (
            .clk(clk), .rst(rst), .enable(en[gi]), .fifo(bus),
            .tx(tx_w[gi]), .busy(busy_w[gi]), .done(done_w[gi])
        );

        assign read_w[gi]  = bus.read;
        assign empty_w[gi] = bus.empty;
        assign rc_w[gi]    = read_cnt;
    end

    typedef struct {
        int         inst;
        logic [3:0] word;
        int         nlev;
        logic [0:6] lv;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int inst, input logic [3:0] w);
        mem[inst][4'(wr_ptr[inst])] = w;
        wr_ptr[inst]++;
    endtask

    task automatic wait_fall(input int inst, input int max, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int n = 1; n <= max; n++) begin
            @(negedge clk);
            if (tx_w[inst] == 1'b0) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL start_timeout: inst %0d no start bit within %0d cycles", inst, max);
        end
    endtask

    // Entered on the first start-bit cycle; walks every cycle of the frame plus the idle cycle after.
    task automatic check_frame(input int inst, input logic [0:6] lv, input int nlev, input int drop_at);
        int f;
        f = nlev * CPB;
        for (int k = 0; k < f; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_at) en[inst] = 1'b0;
            chk($sformatf("tx_i%0d_k%0d", inst, k), 32'(tx_w[inst]), 32'(lv[k / CPB]));
            chk($sformatf("done_i%0d_k%0d", inst, k), 32'(done_w[inst]), 32'(k == f - 1));
            chk($sformatf("busy_i%0d_k%0d", inst, k), 32'(busy_w[inst]), 32'd1);
        end
        @(negedge clk);
        chk($sformatf("idle_busy_i%0d", inst), 32'(busy_w[inst]), 32'd0);
        chk($sformatf("idle_tx_i%0d", inst), 32'(tx_w[inst]), 32'd1);
        chk($sformatf("idle_done_i%0d", inst), 32'(done_w[inst]), 32'd0);
    endtask

    initial begin
        int   lat;
        bit   ok;
        int   rc0;
        int   t_prev;
        logic [0:6] stream_lv [3];

        vecs[0] = '{0, 4'hA, 6, 7'b0010110};
        vecs[1] = '{0, 4'h5, 6, 7'b0101010};
        vecs[2] = '{1, 4'h7, 7, 7'b0111011};
        vecs[3] = '{2, 4'h7, 7, 7'b0111001};
        vecs[4] = '{1, 4'h3, 7, 7'b0110001};
        vecs[5] = '{2, 4'h0, 7, 7'b0000011};

        stream_lv[0] = 7'b0110010;
        stream_lv[1] = 7'b0001110;
        stream_lv[2] = 7'b0111110;

        for (int i = 0; i < 3; i++) begin
            en[i]     = 1'b1;
            wr_ptr[i] = 0;
        end

        // Reset with empty FIFOs
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold_tx", 32'(tx_w[0]), 32'd1);
        chk("rst_hold_busy", 32'(busy_w[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", 32'(tx_w[0]), 32'd1);
        chk("rst_read", 32'(read_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        repeat (50) @(negedge clk);
        chk("rst_no_read", 32'(rc_w[0] + rc_w[1] + rc_w[2]), 32'd0);

        // Single-word frames across the three parity configurations
        for (int v = 0; v < 6; v++) begin
            rc0 = rc_w[vecs[v].inst];
            push(vecs[v].inst, vecs[v].word);
            wait_fall(vecs[v].inst, 20, lat, ok);
            if (ok) begin
                chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
                check_frame(vecs[v].inst, vecs[v].lv, vecs[v].nlev, -1);
            end
            chk($sformatf("vec%0d_reads", v), 32'(rc_w[vecs[v].inst] - rc0), 32'd1);
            chk($sformatf("vec%0d_empty", v), 32'(empty_w[vecs[v].inst]), 32'd1);
        end

        // Back-to-back stream on the default instance
        rc0 = rc_w[0];
        push(0, 4'h3);
        push(0, 4'hC);
        push(0, 4'hF);
        t_prev = 0;
        for (int f = 0; f < 3; f++) begin
            wait_fall(0, 20, lat, ok);
            if (!ok) break;
            if (f > 0) chk($sformatf("stream_spacing%0d", f), 32'(cyc - t_prev), 32'd27);
            t_prev = cyc;
            check_frame(0, stream_lv[f], 6, -1);
        end
        repeat (10) @(negedge clk);
        chk("stream_reads", 32'(rc_w[0] - rc0), 32'd3);
        chk("stream_end_tx", 32'(tx_w[0]), 32'd1);
        chk("stream_end_busy", 32'(busy_w[0]), 32'd0);
        chk("stream_end_empty", 32'(empty_w[0]), 32'd1);

        // Enable gating: no pop while disabled, then drop enable mid-frame
        en[0] = 1'b0;
        rc0 = rc_w[0];
        push(0, 4'h9);
        push(0, 4'h2);
        repeat (20) @(negedge clk);
        chk("gate_no_read", 32'(rc_w[0] - rc0), 32'd0);
        chk("gate_idle_tx", 32'(tx_w[0]), 32'd1);
        en[0] = 1'b1;
        wait_fall(0, 20, lat, ok);
        if (ok) check_frame(0, 7'b0100110, 6, 9);
        repeat (20) @(negedge clk);
        chk("gate_one_read", 32'(rc_w[0] - rc0), 32'd1);
        chk("gate_fifo_left", 32'(empty_w[0]), 32'd0);

        // Reset during DATA bit 2 of word 4'h2, then a fresh frame
        en[0] = 1'b1;
        wait_fall(0, 20, lat, ok);
        if (ok) begin
            repeat (13) @(negedge clk);
            chk("mid_bit2_tx", 32'(tx_w[0]), 32'd0);
            #1 rst = 1'b0;
            #1;
            chk("async_rst_tx", 32'(tx_w[0]), 32'd1);
            chk("async_rst_busy", 32'(busy_w[0]), 32'd0);
            chk("async_rst_read", 32'(read_w[0]), 32'd0);
            chk("async_rst_done", 32'(done_w[0]), 32'd0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
        end
        rc0 = rc_w[0];
        push(0, 4'hB);
        wait_fall(0, 20, lat, ok);
        if (ok) begin
            chk("post_rst_latency", 32'(lat), 32'd3);
            check_frame(0, 7'b0110110, 6, -1);
        end
        chk("post_rst_reads", 32'(rc_w[0] - rc0), 32'd1);
        chk("post_rst_empty", 32'(empty_w[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
